// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. Registered sum/cout/ovf on completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one chunk added per cycle, cnt_q counts down to the last chunk
// ST_DONE | result valid for one cycle; a new start is accepted here
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, last;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  assign accept = start && (state_q != ST_RUN);
  assign last   = (state_q == ST_RUN) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands shift right each cycle so the active chunk is always the low CHUNK bits;
  // on the last chunk those bits hold the operand MSBs used for signed overflow.
  assign csum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign acc_next = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign ovf_next = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (csum[CHUNK-1] != a_q[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= cin ^ sub;
      cnt_q   <= CW'(NCH - 1);
    end else if (state_q == ST_RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= csum[CHUNK];
      acc_q   <= acc_next;
      if (last) begin
        sum  <= acc_next;
        cout <= csum[CHUNK];
        ovf  <= ovf_next;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: directed 16/4 vectors plus random sweeps
// on (16,16), (16,1) and (32,8) against an arithmetic reference model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  function automatic void ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                    input logic ci, input logic sb,
                                    output logic [31:0] s, output logic c, output logic o);
    logic [31:0] mask, bp;
    logic [32:0] full;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bp   = (sb ? ~bv : bv) & mask;
    full = {1'b0, av & mask} + {1'b0, bp} + {32'b0, ci ^ sb};
    s    = full[31:0] & mask;
    c    = full[w];
    o    = (av[w-1] == bp[w-1]) && (s[w-1] != av[w-1]);
  endfunction

  // ---------------- directed DUT (16/4) ----------------
  logic        rst0_n, rst_g;
  logic        start0, cin0, sub0, busy0, done0, cout0, ovf0;
  logic [15:0] a0, b0, sum0;

  logic [31:0] q_s[$];
  bit          q_c[$];
  bit          q_o[$];
  int          q_t[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  always @(negedge clk) begin
    logic [31:0] es;
    int          et;
    if (rst0_n && done0) begin
      if (q_s.size() == 0) begin
        chk("d0 unexpected done", 32'd1, 32'd0);
      end else begin
        es = q_s.pop_front();
        et = q_t.pop_front();
        chk("d0 sum", {16'b0, sum0}, es);
        chk("d0 cout", {31'b0, cout0}, {31'b0, q_c.pop_front()});
        chk("d0 ovf", {31'b0, ovf0}, {31'b0, q_o.pop_front()});
        chk("d0 latency", cyc - et, 32'd4);
        chk("d0 busy with done", {31'b0, busy0}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
    a0 = av; b0 = bv; cin0 = ci; sub0 = sb; start0 = 1'b1;
    q_s.push_back({16'b0, es});
    q_c.push_back(ec);
    q_o.push_back(eo);
    q_t.push_back(cyc + 1);
    @(negedge clk);
    start0 = 1'b0;
    a0 = 16'hDEAD; b0 = 16'hBEEF; cin0 = 1'b1; sub0 = ~sb;
  endtask

  task automatic drain0();
    int n = 0;
    while (q_s.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d0 drain", q_s.size(), 32'd0);
  endtask

  // ---------------- random sweep DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 2) ? 32 : 16;
    localparam int C = (g == 0) ? 16 : (g == 1) ? 1 : 8;
    localparam int N = W / C;

    logic         start, cin, sub, busy, done, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic [31:0]  q_s[$];
    bit           q_c[$];
    bit           q_o[$];
    int           q_t[$];
    bit           fin = 1'b0;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_g), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always @(negedge clk) begin
      logic [31:0] es;
      int          et;
      if (rst_g && done) begin
        if (q_s.size() == 0) begin
          chk($sformatf("sw%0d unexpected done", g), 32'd1, 32'd0);
        end else begin
          es = q_s.pop_front();
          et = q_t.pop_front();
          chk($sformatf("sw%0d sum", g), 32'(sum), es);
          chk($sformatf("sw%0d cout", g), {31'b0, cout}, {31'b0, q_c.pop_front()});
          chk($sformatf("sw%0d ovf", g), {31'b0, ovf}, {31'b0, q_o.pop_front()});
          chk($sformatf("sw%0d latency", g), cyc - et, N);
        end
      end
    end

    initial begin
      logic [31:0] ra, rb, es;
      logic        rc, rs, ec, eo;
      int          n;
      start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      wait (rst_g);
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom; rb = $urandom;
        rc = 1'($urandom); rs = 1'($urandom);
        ref_model(W, ra, rb, rc, rs, es, ec, eo);
        a = W'(ra); b = W'(rb); cin = rc; sub = rs; start = 1'b1;
        q_s.push_back(es); q_c.push_back(ec); q_o.push_back(eo); q_t.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < N + 10) begin
          @(negedge clk);
          n++;
        end
        if ($urandom_range(0, 1) != 0) @(negedge clk);
      end
      n = 0;
      while (q_s.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("sw%0d drain", g), q_s.size(), 32'd0);
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst0_n = 1'b0; rst_g = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy0}, 32'd0);
    chk("reset done", {31'b0, done0}, 32'd0);
    chk("reset sum", {16'b0, sum0}, 32'd0);
    chk("reset cout", {31'b0, cout0}, 32'd0);
    chk("reset ovf", {31'b0, ovf0}, 32'd0);
    rst0_n = 1'b1; rst_g = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("run busy", {31'b0, busy0}, 32'd1);
      chk("run no done", {31'b0, done0}, 32'd0);
      @(negedge clk);
    end
    drain0();

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain0();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain0();
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); drain0();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); drain0();
    issue(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0); drain0();

    // start pulses while busy must be ignored
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    a0 = 16'hFFFF; b0 = 16'hFFFF; start0 = 1'b1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    drain0();

    // back-to-back: start during the done cycle
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    n = 0;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b done seen", {31'b0, done0}, 32'd1);
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    chk("b2b busy after done", {31'b0, busy0}, 32'd1);
    drain0();

    // reset mid-run discards the operation
    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    @(negedge clk);
    rst0_n = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busy0}, 32'd0);
    chk("midrst done", {31'b0, done0}, 32'd0);
    chk("midrst sum", {16'b0, sum0}, 32'd0);
    chk("midrst cout", {31'b0, cout0}, 32'd0);
    chk("midrst ovf", {31'b0, ovf0}, 32'd0);
    q_s.delete(); q_c.delete(); q_o.delete(); q_t.delete();
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0); drain0();

    n = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("sweeps finished", {31'b0, (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
